// File: rtl/pong_game_ctl.sv
// Frame-driven Pong match sequencer: state, scores, serve direction and ball commands.
// Optional speed-up stepping during play is enabled by defining PONG_SPEEDUP_EN.
`timescale 1ns/1ps
module pong_game_ctl #(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 90,
  parameter int SPEEDUP_FRAMES = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       mouse_left,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic [2:0] state,
  output logic       ball_rst,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [1:0] speed,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  if (WIN_SCORE < 1 || WIN_SCORE > 9 || SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
      POINT_FRAMES < 1 || POINT_FRAMES > 255 || SPEEDUP_FRAMES < 1 || SPEEDUP_FRAMES > 255)
  begin : g_bad_param
    $error("pong_game_ctl: parameter out of legal range");
  end

  state_t     state_q, state_d;
  logic       btn_prev;
  logic       go;
  logic [7:0] frame_cnt, frame_cnt_d;
  logic       ball_rst_d, ball_en_d, serve_dir_d;
  logic [3:0] score_l_d, score_r_d;
  logic [1:0] winner_d;

  assign go    = (start | mouse_left) & ~btn_prev;
  assign state = state_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      btn_prev  <= 1'b0;
      frame_cnt <= 8'd0;
      ball_rst  <= 1'b0;
      ball_en   <= 1'b0;
      serve_dir <= 1'b0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 2'd0;
    end else begin
      state_q   <= state_d;
      btn_prev  <= start | mouse_left;
      frame_cnt <= frame_cnt_d;
      ball_rst  <= ball_rst_d;
      ball_en   <= ball_en_d;
      serve_dir <= serve_dir_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      winner    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt;
    ball_rst_d  = 1'b0;
    ball_en_d   = ball_en;
    serve_dir_d = serve_dir;
    score_l_d   = score_l;
    score_r_d   = score_r;
    winner_d    = winner;
    case (state_q)
      IDLE, GAMEOVER: begin
        ball_en_d = 1'b0;
        if (go) begin
          state_d     = SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 2'd0;
          frame_cnt_d = 8'd0;
          serve_dir_d = 1'b0;
          ball_rst_d  = 1'b1;
        end
      end
      SERVE: begin
        ball_en_d = 1'b0;
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) begin
            state_d     = PLAY;
            ball_en_d   = 1'b1;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        // A simultaneous double miss is a dead ball: nobody scores.
        if (miss_l || miss_r) begin
          state_d     = POINT;
          ball_en_d   = 1'b0;
          frame_cnt_d = 8'd0;
          if (miss_l && !miss_r) begin
            score_r_d   = sat_inc(score_r);
            serve_dir_d = 1'b1;
          end else if (miss_r && !miss_l) begin
            score_l_d   = sat_inc(score_l);
            serve_dir_d = 1'b0;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (frame_cnt == POINT_LAST) begin
            frame_cnt_d = 8'd0;
            if (score_l == WIN || score_r == WIN) begin
              state_d  = GAMEOVER;
              winner_d = (score_l == WIN) ? 2'd1 : 2'd2;
            end else begin
              state_d    = SERVE;
              ball_rst_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [7:0] SPEEDUP_LAST = 8'(SPEEDUP_FRAMES - 1);
  logic [7:0] spd_cnt, spd_cnt_d;
  logic [1:0] speed_d;

  // Speed restarts at every serve; only ticks that stay in PLAY count.
  always_comb begin
    spd_cnt_d = spd_cnt;
    speed_d   = speed;
    if (state_d == SERVE && state_q != SERVE) begin
      spd_cnt_d = 8'd0;
      speed_d   = 2'd0;
    end else if (state_q == PLAY && state_d == PLAY && frame_tick) begin
      if (spd_cnt == SPEEDUP_LAST) begin
        spd_cnt_d = 8'd0;
        if (speed != 2'd3) speed_d = speed + 2'd1;
      end else begin
        spd_cnt_d = spd_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spd_cnt <= 8'd0;
      speed   <= 2'd0;
    end else begin
      spd_cnt <= spd_cnt_d;
      speed   <= speed_d;
    end
  end
`else
  assign speed = 2'd0;
`endif

endmodule

// File: tb/tb_pong_game_ctl.sv
// Directed bench for pong_game_ctl with WIN_SCORE=2, SERVE=60, POINT=90, SPEEDUP=4.
`timescale 1ns/1ps
module tb_pong_game_ctl;
  logic       clk = 1'b0;
  logic       rst, frame_tick, start, mouse_left, miss_l, miss_r;
  logic [2:0] state;
  logic       ball_rst, ball_en, serve_dir;
  logic [1:0] speed, winner;
  logic [3:0] score_l, score_r;
  int         passed = 0;
  int         total  = 0;

  pong_game_ctl #(.WIN_SCORE(2), .SERVE_FRAMES(60), .POINT_FRAMES(90), .SPEEDUP_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .mouse_left(mouse_left),
    .miss_l(miss_l), .miss_r(miss_r), .state(state), .ball_rst(ball_rst), .ball_en(ball_en),
    .serve_dir(serve_dir), .speed(speed), .score_l(score_l), .score_r(score_r), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pulse_tick();
      step();
    end
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; mouse_left = 1'b0;
    miss_l = 1'b0; miss_r = 1'b0;
    repeat (3) step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ball_rst", 8'(ball_rst), 8'd0);
    chk("rst_ball_en", 8'(ball_en), 8'd0);
    chk("rst_scores", {score_l, score_r}, 8'h00);
    chk("rst_winner", 8'(winner), 8'd0);
    chk("rst_speed", 8'(speed), 8'd0);

    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    chk("go_state", 8'(state), 8'd1);
    chk("go_ball_rst", 8'(ball_rst), 8'd1);
    chk("go_scores", {score_l, score_r}, 8'h00);
    step();
    chk("go_ball_rst_off", 8'(ball_rst), 8'd0);
    chk("go_held_state", 8'(state), 8'd1);
    start = 1'b0;

    ticks(59);
    chk("serve59_state", 8'(state), 8'd1);
    chk("serve59_ball_en", 8'(ball_en), 8'd0);
    ticks(1);
    chk("serve60_state", 8'(state), 8'd2);
    chk("serve60_ball_en", 8'(ball_en), 8'd1);
    chk("play_speed", 8'(speed), 8'd0);

    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
    chk("play_go_ignored", 8'(state), 8'd2);

    miss_l = 1'b1;
    step();
    miss_l = 1'b0;
    chk("missl_score_r", 8'(score_r), 8'd1);
    chk("missl_serve_dir", 8'(serve_dir), 8'd1);
    chk("missl_state", 8'(state), 8'd3);
    chk("missl_ball_en", 8'(ball_en), 8'd0);
    step();
    ticks(89);
    chk("point89_state", 8'(state), 8'd3);
    pulse_tick();
    chk("point90_state", 8'(state), 8'd1);
    chk("point90_ball_rst", 8'(ball_rst), 8'd1);
    step();
    chk("point90_ball_rst_off", 8'(ball_rst), 8'd0);

    ticks(60);
    chk("serve2_state", 8'(state), 8'd2);
    miss_l = 1'b1; miss_r = 1'b1;
    step();
    miss_l = 1'b0; miss_r = 1'b0;
    chk("double_scores", {score_l, score_r}, 8'h01);
    chk("double_state", 8'(state), 8'd3);
    chk("double_serve_dir", 8'(serve_dir), 8'd1);
    step();
    ticks(90);
    chk("double_back_serve", 8'(state), 8'd1);

    ticks(60);
    miss_r = 1'b1; frame_tick = 1'b1;
    step();
    miss_r = 1'b0; frame_tick = 1'b0;
    chk("missr_score_l", 8'(score_l), 8'd1);
    chk("missr_serve_dir", 8'(serve_dir), 8'd0);
    chk("missr_state", 8'(state), 8'd3);
    step();
    ticks(89);
    chk("coinc_tick_not_counted", 8'(state), 8'd3);
    ticks(1);
    chk("coinc_point_end", 8'(state), 8'd1);

    ticks(60);
    miss_r = 1'b1;
    step();
    miss_r = 1'b0;
    chk("win_score_l", 8'(score_l), 8'd2);
    step();
    miss_l = 1'b1;
    step();
    miss_l = 1'b0;
    chk("point_miss_ignored", {score_l, score_r}, 8'h21);
    step();
    ticks(90);
    chk("over_state", 8'(state), 8'd4);
    chk("over_winner", 8'(winner), 8'd1);
    chk("over_score_l", 8'(score_l), 8'd2);
    chk("over_ball_en", 8'(ball_en), 8'd0);
    miss_r = 1'b1;
    step();
    miss_r = 1'b0;
    ticks(3);
    chk("over_hold_scores", {score_l, score_r}, 8'h21);
    chk("over_hold_state", 8'(state), 8'd4);

    mouse_left = 1'b1;
    step();
    chk("regame_state", 8'(state), 8'd1);
    chk("regame_ball_rst", 8'(ball_rst), 8'd1);
    chk("regame_scores", {score_l, score_r}, 8'h00);
    chk("regame_winner", 8'(winner), 8'd0);
    mouse_left = 1'b0;
    step();
    ticks(60);
    chk("regame_play", 8'(state), 8'd2);

`ifdef PONG_SPEEDUP_EN
    for (int k = 1; k <= 5; k++) begin
      ticks(4);
      chk($sformatf("speed_step%0d", k), 8'(speed), 8'((k > 3) ? 3 : k));
    end
`endif

    rst = 1'b0;
    #2;
    chk("async_rst_state", 8'(state), 8'd0);
    chk("async_rst_speed", 8'(speed), 8'd0);
    chk("async_rst_ball_en", 8'(ball_en), 8'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_ball_rst", 8'(ball_rst), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
